read_rect: RTL
==============

# read_rect

Rectangle read-back scanner for the 160x120 pixel frame buffer. It is the reading counterpart of the rectangle drawing path. Given an origin, width and height, it walks every pixel of the rectangle in raster order and issues one read per cycle to the frame-buffer read port. It compares each returned colour against a target colour and reports whether any pixel matched and how many did. Game logic uses it for collision and occupancy checks before drawing sprites.

## Interface
- COLOUR_W, 3, pixel colour width (matches the VGA adapter colour bus)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- start_x  in  8  rectangle origin x
- start_y  in  8  rectangle origin y
- width  in  8  pixels per row; 0 means an empty rectangle
- height  in  8  rows; 0 means an empty rectangle
- target_colour  in  COLOUR_W  colour to match
- rd_en  out  1  read request to the frame buffer this cycle
- rd_x  out  8  read address x
- rd_y  out  8  read address y
- rd_data  in  COLOUR_W  frame-buffer data, valid exactly 1 cycle after rd_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at the end of a scan
- hit  out  1  at least one pixel matched; held until the next accepted start
- match_count  out  16  number of matching pixels; held until the next accepted start

## Operation
- Reset values: state IDLE; rd_en=0, rd_x=0, rd_y=0, busy=0, done=0, hit=0, match_count=0; internal dx/dy=0.
- IDLE, start=1, width≠0 and height≠0:
  - Latch start_x, start_y, width, height and target_colour.
  - Clear hit and match_count and reset dx/dy to 0.
  - Go to SCAN.
- IDLE, start=1, width=0 or height=0:
  - Latch the inputs, then clear hit and match_count.
  - Go directly to DONE. No reads are issued.
- SCAN:
  - rd_en=1 every cycle; rd_x=sx+dx and rd_y=sy+dy, both truncated to 8 bits (coordinates wrap modulo 256).
  - Offsets cover dx=0..w-1 and dy=0..h-1, x fastest.
  - At dx=w-1: dx returns to 0 and dy increments.
  - After issuing the read at dx=w-1, dy=h-1, go to DRAIN.
- DRAIN: rd_en=0 for one cycle to absorb the last read's data, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Compare pipeline:
  - valid_d is rd_en delayed by one cycle.
  - When valid_d=1 and rd_data equals the latched target, match_count increments and hit is set.
  - Maximum count is 255*255=65025, which fits in 16 bits, so no saturation is needed.
- Latched inputs isolate the scan. Changes to start_x, start_y, width, height or target_colour during a scan have no effect.
- start outside IDLE, including in the DONE cycle, is ignored.
- Reset asserted mid-scan: all outputs return to their reset values immediately (asynchronously), no done pulse is produced, and the pending read's data is discarded.

## Timing
- Let start be accepted at edge 0 and N=width*height.
- rd_en is high for cycles 1..N, with address k (0-based raster index) presented in cycle k+1.
- rd_data for address k is sampled at the end of cycle k+2.
- DRAIN occupies cycle N+1. done is high in cycle N+2. busy is high for cycles 1..N+1.
- hit and match_count are final when done is high.
- Empty rectangle: done is high in cycle 1, busy never rises, and hit and match_count are 0.
- Back-to-back: a start in the first IDLE cycle after done is accepted, so the minimum gap between scans is 1 cycle.

## Structure
- Shared package holds:
  - COORD_W=8 and COUNT_W=16.
  - State encoding IDLE/SCAN/DRAIN/DONE.
  - The frame-buffer read latency constant (1).
- One natural sub-module, rect_raster_counter:
  - Loads w/h, steps dx/dy on enable.
  - Flags the last pixel.
  - Is reusable by the drawing path.

## Test plan
- 2x2 at (10,20), all memory equal to target → reads (10,20),(11,20),(10,21),(11,21) in cycles 1–4; done in cycle 6; match_count=4, hit=1.
- 3x1 at (4,0), only (5,0) equal to target → match_count=1, hit=1; with no matching pixel → match_count=0, hit=0.
- width=0, height=5 → rd_en never high; done in cycle 1; busy stays 0; match_count=0.
- start_x=254, width=4, height=1 → rd_x sequence 254,255,0,1.
- 4x4 scan with reset asserted in cycle 3 → rd_en, busy and outputs go to 0 immediately and no done pulse; a following 1x1 scan completes with match_count≤1.
- start pulsed during SCAN and in the DONE cycle is ignored; full 255x255 scan with all pixels matching → match_count=65025, done in cycle 65027.

Source files
------------

// File: rtl/read_rect_pkg.sv
// Shared constants and state encoding for the rectangle read-back scanner
// and the raster counter it shares with the drawing path.
package read_rect_pkg;
  localparam int COORD_W    = 8;
  localparam int COUNT_W    = 16;
  localparam int RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/read_rect_if.sv
// Request/result handshake plus frame-buffer read port of the scanner.
// slave is the scanner side, master is the requester / frame-buffer side.
interface read_rect_if
  import read_rect_pkg::*;
#(
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [COORD_W-1:0]  start_x;
  logic [COORD_W-1:0]  start_y;
  logic [COORD_W-1:0]  width;
  logic [COORD_W-1:0]  height;
  logic [COLOUR_W-1:0] target_colour;
  logic                rd_en;
  logic [COORD_W-1:0]  rd_x;
  logic [COORD_W-1:0]  rd_y;
  logic [COLOUR_W-1:0] rd_data;
  logic                busy;
  logic                done;
  logic                hit;
  logic [COUNT_W-1:0]  match_count;

  modport slave (
    input  start, start_x, start_y, width, height, target_colour, rd_data,
    output rd_en, rd_x, rd_y, busy, done, hit, match_count
  );

  modport master (
    output start, start_x, start_y, width, height, target_colour, rd_data,
    input  rd_en, rd_x, rd_y, busy, done, hit, match_count
  );
endinterface

// File: rtl/rect_raster_counter.sv
// Raster-order dx/dy offset counter over a w x h rectangle, x fastest.
// last flags the final pixel; w or h of zero must be handled by the caller.
module rect_raster_counter
  import read_rect_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [COORD_W-1:0] w_in,
  input  logic [COORD_W-1:0] h_in,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy,
  output logic               last
);
  logic [COORD_W-1:0] w_q;
  logic [COORD_W-1:0] h_q;
  logic               row_end;

  assign row_end = (dx == w_q - COORD_W'(1));
  assign last    = row_end && (dy == h_q - COORD_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx  <= '0;
      dy  <= '0;
      w_q <= '0;
      h_q <= '0;
    end else if (load) begin
      dx  <= '0;
      dy  <= '0;
      w_q <= w_in;
      h_q <= h_in;
    end else if (en) begin
      if (row_end) begin
        dx <= '0;
        dy <= dy + COORD_W'(1);
      end else begin
        dx <= dx + COORD_W'(1);
      end
    end
  end
endmodule

// File: rtl/read_rect.sv
// Rectangle read-back scanner: issues one frame-buffer read per cycle in
// raster order and counts pixels equal to a latched target colour.
module read_rect
  import read_rect_pkg::*;
#(
  parameter int COLOUR_W = 3
)(
  input  logic      clk,
  input  logic      reset,
  read_rect_if.slave bus
);
  state_t              state, state_nx;
  logic                accept;
  logic                empty;
  logic                last;
  logic [COORD_W-1:0]  dx, dy;
  logic [COORD_W-1:0]  sx_q, sy_q;
  logic [COLOUR_W-1:0] tgt_q;
  logic [RD_LATENCY-1:0] vld_p1;
  logic                match;
  logic                hit_q;
  logic [COUNT_W-1:0]  count_q;
  logic                rd_en;

  assign accept = (state == IDLE) && bus.start;
  assign empty  = (bus.width == '0) || (bus.height == '0);

  rect_raster_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .en    (state == SCAN),
    .w_in  (bus.width),
    .h_in  (bus.height),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = empty ? DONE : SCAN;
      SCAN:    if (last) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = (state == SCAN);
    bus.busy = (state == SCAN) || (state == DRAIN);
    bus.done = (state == DONE);
    bus.rd_x = rd_en ? sx_q + dx : '0;
    bus.rd_y = rd_en ? sy_q + dy : '0;
  end
  assign bus.rd_en = rd_en;

  // Operand latch: the scan only ever sees the values captured at start.
  always_ff @(posedge clk) begin
    if (accept) begin
      sx_q  <= bus.start_x;
      sy_q  <= bus.start_y;
      tgt_q <= bus.target_colour;
    end
  end

  // Stage p1: read data returns RD_LATENCY cycles after its request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];
    end
  end

  assign match = vld_p1[RD_LATENCY-1] && (bus.rd_data == tgt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q   <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      hit_q   <= 1'b0;
      count_q <= '0;
    end else if (match) begin
      hit_q   <= 1'b1;
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.hit         = hit_q;
  assign bus.match_count = count_q;
endmodule
